// File: rtl/fifo_stream_reader.sv
// Drains a FIFO that has a 1-cycle registered read and presents the words as a
// valid/ready stream through a 2-entry buffer, with a delivered-word counter and flush.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                  pop;
    logic [2:0]            credit;
    logic [1:0]            occ_after_pop;

    always_comb begin
        pop           = (occ_q != 2'd0) && m_ready;
        // Slots that will be committed once this edge settles; issuing only below 2
        // keeps occupancy plus the in-flight word within the two buffer slots.
        credit        = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en    = rst_n && !fifo_empty && !flush && (credit < 3'd2);
        occ_after_pop = occ_q - {1'b0, pop};

        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        head_d     = head_q;
        tail_d     = tail_q;
        cnt_d      = cnt_q;

        if (flush) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
        end else begin
            if (pop) begin
                head_d = tail_q;
                cnt_d  = cnt_q + CNT_WIDTH'(1);
            end
            // The arriving word takes the first slot left free after the pop.
            if (inflight_q) begin
                if (occ_after_pop == 2'd0) begin
                    head_d = fifo_rd_data;
                end else begin
                    tail_d = fifo_rd_data;
                end
            end
            occ_d = occ_after_pop + {1'b0, inflight_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q;
    assign word_cnt = cnt_q;

endmodule
